// File: rtl/uart_tx_fifo_if.sv
// Host-side bus of the FIFO-buffered UART transmitter: write handshake,
// FIFO occupancy, serialiser status and the serial line itself.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          start;
  logic [DATA_BITS-1:0]          data;
  logic                          ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          tx_busy;
  logic                          tx_done;
  logic                          tx;

  modport master (
    output start, data,
    input  ready, fifo_count, tx_busy, tx_done, tx
  );

  modport slave (
    input  start, data,
    output ready, fifo_count, tx_busy, tx_done, tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular FIFO; frames stream back to back.
// Define UART_TX_PARITY_EN to compile in a parity bit (even/odd via PARITY_ODD).
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLK_DIV);

  localparam logic [CNTW-1:0] FULL      = CNTW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   RELOAD    = CW'(CLK_DIV - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNTW-1:0]      count;
  logic                 wr_en;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign bus.ready      = (count != FULL);
  assign bus.fifo_count = count;
  assign wr_en          = bus.start && bus.ready;
  assign head           = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.data;
  end

  // Serialiser state
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           bit_idx, bit_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 tx_q, tx_n;
  logic                 done;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_n;
`endif

  assign tick = (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = tick ? cnt : cnt - CW'(1);
    bit_n   = bit_idx;
    sh_n    = sh;
    tx_n    = tx_q;
    pop     = 1'b0;
    done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        pop  = (count != '0);
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          cnt_n   = RELOAD;
          bit_n   = '0;
          tx_n    = sh[0];
        end
      end
      DATA: begin
        if (tick) begin
          cnt_n = RELOAD;
          if (bit_idx == LAST_DATA) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n = bit_idx + 4'd1;
            sh_n  = sh >> 1;
            tx_n  = sh[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          cnt_n   = RELOAD;
          bit_n   = '0;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_n = RELOAD;
          if (bit_idx == LAST_STOP) begin
            done    = 1'b1;
            state_n = IDLE;
            tx_n    = 1'b1;
            pop     = (count != '0);
          end else begin
            bit_n = bit_idx + 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // A pop always launches a fresh frame, from IDLE or straight out of the last stop bit.
    if (pop) begin
      state_n = START;
      cnt_n   = RELOAD;
      sh_n    = head;
      tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n   = (^head) ^ (PARITY_ODD != 0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      tx_q    <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    sh <= sh_n;
`ifdef UART_TX_PARITY_EN
    par <= par_n;
`endif
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = (state != IDLE);
  assign bus.tx_done = done && !reset;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8-bit/1-stop and 7-bit/2-stop instances,
// checking every cycle of each frame against hand-built frame vectors.
module tb_uart_tx_fifo;
  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LA = 10 + P;  // 1 start + 8 data + P + 1 stop
  localparam int LB = 10 + P;  // 1 start + 7 data + P + 2 stop

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_a ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) bus_b ();

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(1))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int sel = 0;
  logic       tx_s, busy_s, done_s, ready_s;
  logic [2:0] cnt_s;
  assign tx_s    = (sel == 0) ? bus_a.tx         : bus_b.tx;
  assign busy_s  = (sel == 0) ? bus_a.tx_busy    : bus_b.tx_busy;
  assign done_s  = (sel == 0) ? bus_a.tx_done    : bus_b.tx_done;
  assign ready_s = (sel == 0) ? bus_a.ready      : bus_b.ready;
  assign cnt_s   = (sel == 0) ? bus_a.fifo_count : bus_b.fifo_count;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Frame vectors, bit k = line level during bit period k; parity given by hand.
  function automatic logic [15:0] fr_a(input logic [7:0] w, input logic par);
    return (P == 1) ? {5'b0, 1'b1, par, w, 1'b0} : {6'b0, 1'b1, w, 1'b0};
  endfunction

  function automatic logic [15:0] fr_b(input logic [6:0] w, input logic par);
    return (P == 1) ? {5'b0, 2'b11, par, w, 1'b0} : {6'b0, 2'b11, w, 1'b0};
  endfunction

  task automatic drive(input logic st, input logic [7:0] w);
    if (sel == 0) begin
      bus_a.start = st;
      bus_a.data  = w;
    end else begin
      bus_b.start = st;
      bus_b.data  = w[6:0];
    end
  endtask

  // Entered #1 after the edge that drove the start bit; leaves #1 after the last frame cycle.
  task automatic check_frame(input string tag, input logic [15:0] fr, input int len);
    int f;
    f = len * CLK_DIV;
    for (int k = 0; k < f; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      check({tag, "_tx"}, int'(tx_s), int'(fr[k / CLK_DIV]));
      check({tag, "_busy"}, int'(busy_s), 1);
      check({tag, "_done"}, int'(done_s), (k == f - 1) ? 1 : 0);
    end
  endtask

  task automatic send_single(input string tag, input logic [7:0] w,
                             input logic [15:0] fr, input int len);
    drive(1'b1, w);
    @(posedge clk); #1;
    drive(1'b0, w);
    check({tag, "_cnt_acc"}, int'(cnt_s), 1);
    check({tag, "_tx_acc"}, int'(tx_s), 1);
    check({tag, "_busy_acc"}, int'(busy_s), 0);
    @(posedge clk); #1;
    check({tag, "_cnt_pop"}, int'(cnt_s), 0);
    check_frame(tag, fr, len);
    @(posedge clk); #1;
    check({tag, "_busy_end"}, int'(busy_s), 0);
    check({tag, "_tx_end"}, int'(tx_s), 1);
    check({tag, "_done_end"}, int'(done_s), 0);
  endtask

  logic [7:0] words [6] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h3C, 8'h81};
  int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
  int exp_rdy [6] = '{1, 1, 1, 1, 0, 0};

  initial begin
    bus_a.start = 1'b0;
    bus_a.data  = '0;
    bus_b.start = 1'b0;
    bus_b.data  = '0;

    @(posedge clk);
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      check("rst_tx", int'(tx_s), 1);
      check("rst_busy", int'(busy_s), 0);
      check("rst_done", int'(done_s), 0);
      check("rst_ready", int'(ready_s), 1);
      check("rst_cnt", int'(cnt_s), 0);
    end
    reset = 1'b0;
    sel = 0;
    @(posedge clk); #1;

    // 0xA5, 4 ones -> even parity 0
    send_single("a5", 8'hA5, fr_a(8'hA5, 1'b0), LA);
    // 0x07, 3 ones -> even parity 1
    send_single("p07e", 8'h07, fr_a(8'h07, 1'b1), LA);

    // Six-cycle burst: five accepted, the sixth dropped, five frames back to back.
    fork
      begin
        drive(1'b1, words[0]);
        for (int i = 0; i < 6; i++) begin
          @(posedge clk); #1;
          check("burst_cnt", int'(cnt_s), exp_cnt[i]);
          check("burst_ready", int'(ready_s), exp_rdy[i]);
          if (i < 5) drive(1'b1, words[i + 1]);
          else       drive(1'b0, 8'h00);
        end
      end
      begin
        @(posedge clk);
        @(posedge clk); #1;
        for (int f = 0; f < 5; f++) begin
          if (f > 0) begin
            @(posedge clk); #1;
          end
          check_frame("burst", fr_a(words[f], 1'b0), LA);
        end
        @(posedge clk); #1;
        check("burst_idle_busy", int'(busy_s), 0);
        check("burst_idle_cnt", int'(cnt_s), 0);
        repeat (2 * CLK_DIV) @(posedge clk);
        #1;
        check("burst_no_extra", int'(busy_s), 0);
      end
    join

    // 7 data bits, 2 stop bits, odd parity: 0x7F (7 ones) -> 0, 0x07 (3 ones) -> 0
    sel = 1;
    #0;
    send_single("b7f", 8'h7F, fr_b(7'h7F, 1'b0), LB);
    send_single("b07", 8'h07, fr_b(7'h07, 1'b0), LB);

    // Reset mid-frame with two words still queued.
    sel = 0;
    #0;
    drive(1'b1, 8'h11);
    @(posedge clk); #1;
    drive(1'b1, 8'h22);
    @(posedge clk); #1;
    check("rsm_tx_start", int'(tx_s), 0);
    drive(1'b1, 8'h33);
    @(posedge clk); #1;
    drive(1'b0, 8'h00);
    check("rsm_cnt_q", int'(cnt_s), 2);
    repeat (13) @(posedge clk);
    #1;
    check("rsm_busy_pre", int'(busy_s), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rsm_tx", int'(tx_s), 1);
    check("rsm_busy", int'(busy_s), 0);
    check("rsm_cnt", int'(cnt_s), 0);
    check("rsm_ready", int'(ready_s), 1);
    check("rsm_done", int'(done_s), 0);
    for (int k = 0; k < 3 * LA * CLK_DIV; k++) begin
      @(posedge clk); #1;
      check("rsm_quiet_tx", int'(tx_s), 1);
      check("rsm_quiet_done", int'(done_s), 0);
      check("rsm_quiet_busy", int'(busy_s), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO. Serialises words of configurable width at a fixed clock-divided bit rate, with configurable stop bits and optional compiled-in parity. Sits between a byte-producing host and the serial `tx` pin. Back-to-back writes stream out as contiguous frames without host-side pacing.

## Interface
Parameters:
- `CLK_DIV`, 16: clock cycles per bit period; legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, 1: number of stop bits; 1 or 2.
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥ 2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity. Used only with `UART_TX_PARITY_EN`.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  write strobe; `data` is accepted on an edge where `start && ready`.
- `data`  in  DATA_BITS  word to transmit; sampled only on acceptance.
- `ready`  out  1  high when the FIFO is not full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- `tx_busy`  out  1  high whenever the serialiser is not IDLE.
- `tx_done`  out  1  one-cycle pulse at the end of each frame's last stop bit.
- `tx`  out  1  serial line; idle-high; registered output.

## Operation
- FIFO: circular buffer with read/write pointers.
  - `start` while `!ready` is ignored, and the word is dropped.
  - A write and a pop in the same cycle leave `fifo_count` unchanged.
  - `ready` is computed from the current count only, so a write is refused when full even if a pop occurs that cycle.
- Serialiser FSM states: IDLE, START, DATA, PARITY (present only with macro), STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for one bit period, then go to DATA.
  - DATA: shift out the word LSB first, one bit per period, for DATA_BITS bits. Then go to PARITY, or to STOP without the macro.
  - PARITY: one bit period. Bit value = XOR of data bits, XOR `PARITY_ODD`.
  - STOP: `tx`=1 for STOP_BITS bit periods.
- End of the final stop period:
  - Assert `tx_done` for one cycle.
  - If the FIFO is non-empty, pop and enter START directly, with no idle cycle between frames.
  - Otherwise go to IDLE.
- Bit timing: a down-counter reloads to CLK_DIV-1 on every state or bit change. The bit advances when the counter reaches 0.
- Reset, including mid-frame: the frame is aborted, the FIFO is cleared, and no `tx_done` is produced for the aborted frame.
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, `ready`=1, `fifo_count`=0, state IDLE.

## Timing
- With the serialiser IDLE and the FIFO empty, a word accepted at edge N is handled as follows:
  - Edge N: `fifo_count`=1.
  - Edge N+1: the word is popped, `tx` falls, `tx_busy` rises.
- Frame length: F = (1 + DATA_BITS + P + STOP_BITS) × CLK_DIV cycles, where P = 1 with the macro and 0 without it.
- Frame pulse and return to idle, with the start bit driven from edge N+1:
  - `tx_done` is high during the cycle after edge N+F.
  - With nothing queued, `tx_busy` falls at edge N+1+F.
- Streaming: the next frame's start bit begins at edge N+1+F, so `tx` is continuous.
- `tx` is glitch-free and changes only at bit boundaries.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state exists.
  - One parity bit per frame, after the data bits, per `PARITY_ODD`.
- `UART_TX_PARITY_EN` not defined:
  - No PARITY state and no parity logic.
  - `PARITY_ODD` is ignored.
  - Frames are start + data + stop only.

## Test plan
All scenarios use `CLK_DIV`=4 and `FIFO_DEPTH`=4 unless stated otherwise.
- Single word 0xA5, 8N1, no macro:
  - `tx` is 0, then 1,0,1,0,0,1,0,1, then 1, with each bit held 4 cycles.
  - `tx_done` pulses 40 cycles after `tx` falls.
  - `tx_busy` is low again 1 cycle after the pulse.
- `start` held for 6 consecutive cycles with data 0x00,0xFF,0x55,0xAA,0x3C,0x81:
  - The first 5 words are accepted.
  - `ready` falls after the 5th; 0x81 is dropped.
  - 5 contiguous frames run for 200 cycles with no idle gap.
  - `tx_done` pulses 5 times, 40 cycles apart.
- Macro defined, `PARITY_ODD`=0, word 0x07: parity bit = 1, frame = 44 cycles.
- Macro defined, `PARITY_ODD`=1, word 0x07: parity bit = 0.
- `DATA_BITS`=7, `STOP_BITS`=2, word 0x7F, no macro:
  - `tx` is 0, then seven 1s, then two stop 1s.
  - Frame = 40 cycles.
- `reset` asserted for 1 cycle, 15 cycles into a frame, with 2 words queued:
  - `tx`=1, `tx_busy`=0, `fifo_count`=0, `ready`=1 at the next edge.
  - No `tx_done` pulse occurs and no further frames are sent.
